// File: rtl/synch_fifo_wr_arb.sv
// synch_fifo_wr_arb: round-robin packet arbiter sharing one FIFO write port, with a stall watchdog
module synch_fifo_wr_arb #(
  parameter int NUM_REQ = 4,
  parameter int DW = 32,
  parameter int STALL_MAX = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DW-1:0]         fifo_data,
  output logic [IW-1:0]         fifo_src,
  output logic [IW-1:0]         grant_id,
  output logic                  locked,
  output logic                  stall_err
);
  localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, pick, nxt;
  logic [SW-1:0] stall_cnt;
  logic gv, accept;
  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    pick = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[(int'(rr_ptr) + i) % NUM_REQ]) pick = IW'((int'(rr_ptr) + i) % NUM_REQ);
  end
  assign nxt = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign locked = (state == LOCK);
  assign gv = req_valid[grant_id];
  assign accept = locked & gv & ~fifo_full;
  assign req_ready = (locked && !fifo_full) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id : '0;
  assign fifo_wr_en = accept;
  assign fifo_data = req_data[grant_id*DW +: DW];
  assign fifo_src = grant_id;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      stall_err <= 1'b0;
      if (state == IDLE) begin
        stall_cnt <= '0;
        if (|req_valid) begin
          grant_id <= pick;
          state <= LOCK;
        end
      end else if (accept) begin
        stall_cnt <= '0;
        if (req_last[grant_id]) begin
          state <= IDLE;
          rr_ptr <= nxt;
        end
      end else if (!gv) begin
        if (stall_cnt == SW'(STALL_MAX - 1)) begin
          stall_err <= 1'b1;
          state <= IDLE;
          rr_ptr <= nxt;
        end else stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_synch_fifo_wr_arb.sv
// tb_synch_fifo_wr_arb: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_synch_fifo_wr_arb;
  localparam int NR = 4, DW = 32, SM = 4, IW = 2;
  logic clk = 0, rst_ = 0, fifo_full = 0;
  logic [NR-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [NR*DW-1:0] req_data = '0;
  logic fifo_wr_en, locked, stall_err;
  logic [DW-1:0] fifo_data;
  logic [IW-1:0] fifo_src, grant_id;
  int n_chk = 0, n_err = 0;
  int m_g, m_rr, m_idle;
  bit m_lock, m_err;
  logic [NR-1:0] acc;
  int left[NR];
  int pct[NR] = '{90, 70, 50, 30};

  synch_fifo_wr_arb #(.NUM_REQ(NR), .DW(DW), .STALL_MAX(SM)) dut (
    .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .fifo_src(fifo_src), .grant_id(grant_id), .locked(locked), .stall_err(stall_err));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // compares all outputs with the model at the negedge, then advances the model across the posedge
  task automatic cycle();
    logic [NR-1:0] er;
    bit ew;
    @(negedge clk);
    er = (m_lock && !fifo_full) ? NR'(1) << m_g : '0;
    ew = m_lock && req_valid[m_g] && !fifo_full;
    chk("ready", req_ready, er);
    chk("wr_en", fifo_wr_en, ew);
    chk("locked", locked, m_lock);
    chk("grant", grant_id, m_g);
    chk("stall_err", stall_err, m_err);
    chk("data", fifo_data, req_data[m_g*DW +: DW]);
    chk("src", fifo_src, m_g);
    acc = ew ? er : '0;
    m_err = 0;
    if (!m_lock) begin
      m_idle = 0;
      for (int k = NR - 1; k >= 0; k--)
        if (req_valid[(m_rr + k) % NR]) begin
          m_g = (m_rr + k) % NR;
          m_lock = 1;
        end
    end else if (ew) begin
      m_idle = 0;
      if (req_last[m_g]) begin
        m_lock = 0;
        m_rr = (m_g + 1) % NR;
      end
    end else if (!req_valid[m_g]) begin
      m_idle++;
      if (m_idle == SM) begin
        m_err = 1;
        m_lock = 0;
        m_rr = (m_g + 1) % NR;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_ = 0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_stall_err", stall_err, 0);
    chk("rst_grant", grant_id, 0);
    req_valid = '0;
    req_last = '0;
    fifo_full = 0;
    m_lock = 0; m_g = 0; m_rr = 0; m_idle = 0; m_err = 0;
    @(negedge clk);
    #3 rst_ = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    // single producer, three-beat packet
    req_valid = 4'b0010;
    req_data[DW +: DW] = 32'hA;
    cycle();
    chk("b_grant", grant_id, 1);
    for (int b = 0; b < 3; b++) begin
      req_data[DW +: DW] = 32'hA + b;
      req_last[1] = (b == 2);
      #1;
      chk("b_wr", fifo_wr_en, 1);
      chk("b_src", fifo_src, 1);
      chk("b_data", fifo_data, 32'hA + b);
      cycle();
    end
    req_valid = '0;
    req_last = '0;
    #1 chk("b_idle", locked, 0);
    req_valid = '1;
    cycle();
    chk("b_rr_next", grant_id, 2);
    // fairness: all valid, 2-beat packets
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      req_last = '0;
      #1 chk("c_idle", locked, 0);
      cycle();
      chk("c_grant", grant_id, k % NR);
      for (int b = 0; b < 2; b++) begin
        req_last = (b == 1) ? '1 : '0;
        #1 chk("c_wr", fifo_wr_en, 1);
        cycle();
      end
    end
    req_valid = '0;
    req_last = '0;
    // back-pressure mid-packet
    req_valid = 4'b0010;
    cycle();
    chk("d_grant", grant_id, 1);
    req_data[DW +: DW] = 32'h100;
    #1 chk("d_wr0", fifo_wr_en, 1);
    cycle();
    req_data[DW +: DW] = 32'h101;
    fifo_full = 1;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("d_ready", req_ready, 0);
      chk("d_wr", fifo_wr_en, 0);
      chk("d_stall", stall_err, 0);
      cycle();
    end
    fifo_full = 0;
    req_last[1] = 1;
    #1;
    chk("d_wr1", fifo_wr_en, 1);
    chk("d_data1", fifo_data, 32'h101);
    cycle();
    req_valid = '0;
    req_last = '0;
    #1 chk("d_done", locked, 0);
    chk("d_noerr", stall_err, 0);
    // stall watchdog
    do_reset();
    req_valid = 4'b0100;
    cycle();
    chk("e_grant", grant_id, 2);
    #1 chk("e_wr", fifo_wr_en, 1);
    cycle();
    req_valid = 4'b1000;
    for (int s = 0; s < SM; s++) begin
      #1;
      chk("e_nostall", stall_err, 0);
      chk("e_locked", locked, 1);
      cycle();
    end
    #1;
    chk("e_stall_err", stall_err, 1);
    chk("e_unlocked", locked, 0);
    cycle();
    chk("e_next_grant", grant_id, 3);
    chk("e_err_pulse", stall_err, 0);
    // reset mid-packet
    do_reset();
    req_valid = 4'b0010;
    cycle();
    cycle();
    chk("f_midpkt", locked, 1);
    do_reset();
    req_valid = 4'b1010;
    cycle();
    chk("f_grant", grant_id, 1);
    // single-beat packet then wrap from rr_ptr=3
    do_reset();
    req_valid = 4'b0100;
    req_last = 4'b0100;
    cycle();
    #1 chk("g_wr", fifo_wr_en, 1);
    cycle();
    #1 chk("g_single", locked, 0);
    req_valid = 4'b0001;
    req_last = '0;
    cycle();
    chk("g_wrap", grant_id, 0);
    // randomized traffic
    do_reset();
    acc = '0;
    for (int i = 0; i < NR; i++) left[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) left[i]--;
        if (left[i] == 0 && $urandom_range(0, 3) == 0) left[i] = $urandom_range(1, 4);
        req_valid[i] = (left[i] > 0) && ($urandom_range(0, 99) < pct[i]);
        req_last[i] = req_valid[i] ? (left[i] == 1) : 1'($urandom_range(0, 1));
        req_data[i*DW +: DW] = $urandom;
      end
      fifo_full = ($urandom_range(0, 4) == 0);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/synch_fifo_wr_arb.md
# synch_fifo_wr_arb

Round-robin write-side arbiter sharing one `synch_fifo` write port among `NUM_REQ` producers. Each producer sends packets as beats with a `last` marker over a valid/ready handshake. Once a producer is granted, it holds the port until its `last` beat is written, so packets never interleave in the FIFO. Each written beat is tagged with the source ID for the consumer. A watchdog releases a grant when the granted producer stalls mid-packet.

## Interface
- `NUM_REQ`, 4: number of producers, 2..16.
- `DW`, 32: data width, matches the FIFO's `DW`.
- `STALL_MAX`, 64: cycles of missing valid on a locked producer before forced release, ≥1.
- `IW`, localparam = max(1, $clog2(NUM_REQ)): source-ID width.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock, all state on rising edge.
- `rst_` in 1: asynchronous active-low reset.
- `req_valid` in NUM_REQ: per-producer beat valid.
- `req_last` in NUM_REQ: per-producer last-beat flag, qualified by valid.
- `req_data` in NUM_REQ*DW: producer i data at bits [i*DW +: DW].
- `req_ready` out NUM_REQ: per-producer beat accepted when valid&ready.
- `fifo_full` in 1: from the FIFO.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_data` out DW: data of the granted producer.
- `fifo_src` out IW: ID of the granted producer, written alongside the data.
- `grant_id` out IW: current or last grant.
- `locked` out 1: a grant is held.
- `stall_err` out 1: one-cycle pulse on a watchdog release.

## Operation
- The FSM has two states: IDLE and LOCK.
- **IDLE behaviour**
  - `req_ready` = 0 and `fifo_wr_en` = 0.
  - If any `req_valid` is set, select the first set bit searching upward from `rr_ptr` with wrap, e.g. `rr_ptr`=2, NUM_REQ=4 gives order 2,3,0,1.
  - Register the winner into `grant_id` and go to LOCK.
- **LOCK behaviour**, with g = `grant_id`:
  - `req_ready[g]` = ~`fifo_full`; all other ready bits are 0.
  - `fifo_wr_en` = `req_valid[g]` & ~`fifo_full`.
  - `fifo_data` = `req_data[g]` and `fifo_src` = g, both combinational.
- **Leaving LOCK**
  - When a beat with `req_last[g]` is accepted: go to IDLE and set `rr_ptr` ← (g+1) mod NUM_REQ.
- **Stall watchdog**
  - `stall_cnt` clears on every accepted beat and on entry to LOCK.
  - It increments each LOCK cycle where `req_valid[g]`=0.
  - Cycles where valid=1 and full=1 are back-pressure, not a stall: the counter holds.
  - When the counter reaches STALL_MAX−1 and increments: pulse `stall_err`, go to IDLE, set `rr_ptr` ← g+1. No FIFO write occurs in that cycle.
- `locked` = (state==LOCK).
- `fifo_data` and `fifo_src` are don't-care when `fifo_wr_en`=0. Drive them from g anyway; they must never be X after reset.
- **Reset** (asynchronous, any time, including mid-packet):
  - State → IDLE; `rr_ptr`, `grant_id` and `stall_cnt` → 0; `stall_err` → 0.
  - All ready bits and `fifo_wr_en` → 0.
  - A partially written packet stays in the FIFO. Recovery is the consumer's responsibility.

## Timing
- Arbitration costs one cycle: valid sampled in IDLE at edge N, grant registered, first write possible in cycle N+1.
- Per-packet overhead is exactly one idle cycle. A k-beat packet with no back-pressure occupies k+1 cycles.
- Within LOCK, throughput is one beat per cycle while valid=1 and full=0.
- `fifo_wr_en` is combinational from `req_valid`, `fifo_full` and registered state. There is no combinational path from `req_last` to any output.
- `req_ready[g]` does not depend on `req_valid[g]`, so there is no valid→ready loop.
- The `fifo_full` → `req_ready` path is combinational. The FIFO's `full` is registered-pointer derived, so this path is short.
- A single-beat packet (valid&last in the first LOCK cycle) returns to IDLE after one cycle.
- `stall_err` is registered and high for exactly the cycle after the release edge. `locked` goes 0 in that same cycle.

## Test plan
- **Single producer:** after reset, producer 1 sends 3 beats A,B,C with last on C; fifo_full=0. Expect `fifo_wr_en` high for cycles 1–3 after the grant, `fifo_src`=1 on each, then IDLE with `rr_ptr`=2.
- **Fairness:** all four valid continuously, each packet 2 beats. Expect grant order 0,1,2,3,0 with no interleaving, and 3 cycles per packet.
- **Back-pressure:** fifo_full=1 for 5 cycles mid-packet. Expect `req_ready`=0 and no writes during those cycles, no `stall_err`, and the packet resumes with no beat lost or duplicated.
- **Stall:** STALL_MAX=4; producer 2 drops valid after beat 1. Expect `stall_err` pulse 4 cycles later, `locked`=0, and producer 3 granted next if valid.
- **Reset mid-packet:** assert `rst_` asynchronously between edges. Expect outputs 0 immediately. After release with producers 1 and 3 valid, expect the grant to go to 1, since `rr_ptr`=0.
- **Wrap:** NUM_REQ=4, `rr_ptr`=3, only producer 0 valid. Expect `grant_id`=0.
